mul_seq: RTL and testbench
==========================

# mul_seq

Sequenced multiplier stage: each iteration latches one weight and multiplies the next `num_reads_per_iter` activation vectors (NUM_INPUTS lanes) by it, repeating for `num_iters` iterations. Supports signed or unsigned operands. A credit-guarded output FIFO absorbs downstream back-pressure. The block sits between the activation/weight readers and the adder/accumulator stage of the conv pipeline.

## Interface
- NUM_INPUTS, 8, activation lanes (outputs == inputs)
- DATA_WIDTH, 8, operand width; each product is 2*DATA_WIDTH
- LOG_MAX_ITERS, 16, width of the iteration counter
- LOG_MAX_READS_PER_ITER, 16, width of the reads-per-iteration counter
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥4
- clk  in  1  clock; everything is rising-edge
- rst  in  1  asynchronous, active-low reset
- configure  in  1  start pulse; honoured only in IDLE
- num_iters  in  LOG_MAX_ITERS  iterations (= weights consumed); sampled on configure
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  activation vectors per iteration; sampled on configure
- signed_mode  in  1  1 = two's-complement operands; sampled on configure
- act_data_in  in  NUM_INPUTS*DATA_WIDTH  activation vector; lane i in bits [i*DW +: DW]
- act_valid_in  in  1  activation write
- act_avail_out  out  1  block can accept an activation this cycle
- weight_data_in  in  DATA_WIDTH  weight
- weight_valid_in  in  1  weight write
- weight_avail_out  out  1  block can accept a weight this cycle
- data_out  out  2*NUM_INPUTS*DATA_WIDTH  products; lane i in bits [i*2DW +: 2DW]
- valid_out  out  1  output write
- avail_in  in  1  downstream can accept this cycle
- busy_out  out  1  high in any state other than IDLE
- done_out  out  1  one-cycle pulse when the job completes

## Operation
- Handshake (all three interfaces): a transfer occurs in any cycle where valid is high. A source may assert valid only in a cycle where the sink's avail is high. Any valid asserted while avail is low is ignored.
- States and transitions:
  - IDLE → LOAD_W on configure, when both counts are nonzero.
  - If either count is zero: stay in IDLE and pulse done_out on the next cycle.
  - LOAD_W: weight_avail_out=1. The accepted weight is stored, the reads counter is loaded, and the FSM moves to RUN.
  - RUN: act_avail_out = reads_left≠0 && (fifo_count + inflight) < FIFO_DEPTH, where inflight is the number of valid pipeline stages (0..1). Each accepted vector decrements reads_left.
  - On the last read: go to LOAD_W if iters_left>1 (decrement iters_left), otherwise go to DRAIN.
  - DRAIN: wait until the pipeline and the FIFO are empty. Then pulse done_out and go to IDLE.
- Arithmetic:
  - signed_mode=1: both operands are sign-extended to 2*DW, and the product is exact two's complement.
  - signed_mode=0: both operands are zero-extended.
  - The result is always exact (no truncation or saturation).
- Output: valid_out = fifo_not_empty && avail_in. Each valid_out pops one entry. data_out = FIFO head when valid_out=1, else 0.
- configure outside IDLE is ignored. The latched config is unaffected by input changes mid-job.
- Reset (any time, including mid-job): state=IDLE, counters=0, FIFO and pipeline flushed. All outputs are 0: act_avail_out, weight_avail_out, valid_out, data_out, busy_out, done_out.

## Timing
- Activation accepted at cycle t: product register loaded at t+1, FIFO written at t+2. valid_out is earliest at t+2 if avail_in=1 (latency 2).
- Simultaneous FIFO push and pop in one cycle: both happen and fifo_count is unchanged. A pop does not return credit in the same cycle; act_avail_out rises at the earliest in the following cycle.
- The weight for iteration k+1 is accepted no earlier than one cycle after the last read of iteration k. Each product uses the weight latched for its own iteration, because the weight register is captured with the activation in the pipeline.
- done_out: one cycle after the FIFO drains, or one cycle after a zero-count configure. busy_out drops in the same cycle done_out pulses.
- Steady-state throughput: one vector per cycle while avail_in=1.

## Structure
- Package mul_seq_pkg:
  - state enum (IDLE, LOAD_W, RUN, DRAIN)
  - localparam PROD_WIDTH = 2*DATA_WIDTH
  - function for signed/unsigned extension
- Sub-module mul_out_fifo: synchronous FIFO with width 2*NUM_INPUTS*DW, depth FIFO_DEPTH, and count, empty and full outputs.
- The lane multipliers use a generate loop in mul_seq; there is no separate module.

## Test plan
- Unsigned, iters=2, reads=3, weights 3 and 5, acts lane i = i+1, avail_in=1 → 6 outputs: lane i = 3(i+1) ×3, then 5(i+1) ×3. Exactly 2 weight transfers, done_out pulses once.
- Signed, weight=0xFF (−1), act lanes 0x80 → each 16-bit lane = 0x0080 (+128). Same data unsigned → 0x7F80.
- Hold avail_in=0 with acts offered every cycle → exactly FIFO_DEPTH vectors accepted. act_avail_out=0 afterwards, no overflow. Release → all drain in order.
- configure with num_reads_per_iter=0 → no avail asserted, done_out one cycle later, busy_out stays 0.
- configure during RUN with different counts → ignored, and the original job completes with the original counts.
- Assert rst mid-RUN with FIFO holding 2 entries → all outputs 0 immediately. After release, a new job produces only new results.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the sequenced multiplier stage.
// Operand extension is written against a wide carrier so any operand width up to 32 bits works.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoadW,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned PROD_WIDTH   = 2 * DefDataWidth;
  localparam int unsigned ExtWidth     = 64;

  // Extend the low w bits of v to ExtWidth, signed or unsigned; bits above w must be zero.
  function automatic logic [ExtWidth-1:0] extend_op(input logic [ExtWidth-1:0] v,
                                                    input int unsigned         w,
                                                    input logic                sgn);
    logic [ExtWidth-1:0] mask;
    logic [ExtWidth-1:0] top;
    logic                msb;
    mask = ~({ExtWidth{1'b1}} << w);
    top  = v >> (w - 1);
    msb  = sgn & top[0];
    return (v & mask) | ({ExtWidth{msb}} & ~mask);
  endfunction

endpackage

// File: rtl/mul_out_fifo.sv
// Synchronous output FIFO for product vectors; power-of-two depth, registered occupancy count.
module mul_out_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AddrW'(do_push);
    rd_ptr_d = rd_ptr_q + AddrW'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed through count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Sequenced multiplier: one weight per iteration times N activation vectors, with a
// credit-guarded output FIFO so downstream stalls never overflow the single pipeline stage.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned NUM_INPUTS             = 8,
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned LOG_MAX_ITERS          = 16,
  parameter int unsigned LOG_MAX_READS_PER_ITER = 16,
  parameter int unsigned FIFO_DEPTH             = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  configure,
  input  logic [LOG_MAX_ITERS-1:0]              num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]     num_reads_per_iter,
  input  logic                                  signed_mode,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]      act_data_in,
  input  logic                                  act_valid_in,
  output logic                                  act_avail_out,
  input  logic [DATA_WIDTH-1:0]                 weight_data_in,
  input  logic                                  weight_valid_in,
  output logic                                  weight_avail_out,
  output logic [2*NUM_INPUTS*DATA_WIDTH-1:0]    data_out,
  output logic                                  valid_out,
  input  logic                                  avail_in,
  output logic                                  busy_out,
  output logic                                  done_out
);

  localparam int unsigned ProdW    = 2 * DATA_WIDTH;
  localparam int unsigned OutW     = NUM_INPUTS * ProdW;
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW     = FifoCntW + 1;
  localparam int unsigned ItW      = LOG_MAX_ITERS;
  localparam int unsigned RdW      = LOG_MAX_READS_PER_ITER;

  state_e                state_q, state_d;
  logic [ItW-1:0]        iters_q, iters_d;
  logic [RdW-1:0]        reads_left_q, reads_left_d;
  logic [RdW-1:0]        reads_cfg_q, reads_cfg_d;
  logic                  signed_q, signed_d;
  logic [DATA_WIDTH-1:0] weight_q, weight_d;
  logic                  done_q, done_d;
  logic [OutW-1:0]       prod_q, prod_d, prod_c;
  logic                  prod_valid_q, prod_valid_d;

  logic                  act_fire, weight_fire;
  logic [FifoCntW-1:0]   fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [OutW-1:0]       fifo_rdata;
  logic [OccW-1:0]       occupancy;

  // Credit counts the product register too, so a vector in flight always has a FIFO slot.
  assign occupancy = {1'b0, fifo_count} + OccW'(prod_valid_q);

  assign act_avail_out    = (state_q == StRun) && (reads_left_q != '0) && !fifo_full &&
                            (occupancy < OccW'(FIFO_DEPTH));
  assign weight_avail_out = (state_q == StLoadW);
  assign act_fire         = act_valid_in && act_avail_out;
  assign weight_fire      = weight_valid_in && weight_avail_out;

  assign valid_out = !fifo_empty && avail_in;
  assign data_out  = valid_out ? fifo_rdata : '0;
  assign busy_out  = (state_q != StIdle);
  assign done_out  = done_q;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    logic [ProdW-1:0] act_ext;
    logic [ProdW-1:0] wgt_ext;
    assign act_ext = ProdW'(extend_op(ExtWidth'(act_data_in[i*DATA_WIDTH +: DATA_WIDTH]),
                                      DATA_WIDTH, signed_q));
    assign wgt_ext = ProdW'(extend_op(ExtWidth'(weight_q), DATA_WIDTH, signed_q));
    // Low 2*DW bits of the product of extended operands are exact in both modes.
    assign prod_c[i*ProdW +: ProdW] = act_ext * wgt_ext;
  end

  always_comb begin
    prod_valid_d = act_fire;
    prod_d       = act_fire ? prod_c : prod_q;
  end

  always_comb begin
    state_d      = state_q;
    iters_d      = iters_q;
    reads_left_d = reads_left_q;
    reads_cfg_d  = reads_cfg_q;
    signed_d     = signed_q;
    weight_d     = weight_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (configure) begin
          if ((num_iters != '0) && (num_reads_per_iter != '0)) begin
            state_d     = StLoadW;
            iters_d     = num_iters;
            reads_cfg_d = num_reads_per_iter;
            signed_d    = signed_mode;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StLoadW: begin
        if (weight_fire) begin
          weight_d     = weight_data_in;
          reads_left_d = reads_cfg_q;
          state_d      = StRun;
        end
      end
      StRun: begin
        if (act_fire) begin
          reads_left_d = reads_left_q - RdW'(1);
          if (reads_left_q == RdW'(1)) begin
            if (iters_q > ItW'(1)) begin
              iters_d = iters_q - ItW'(1);
              state_d = StLoadW;
            end else begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (!prod_valid_q && fifo_empty) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      iters_q      <= '0;
      reads_left_q <= '0;
      reads_cfg_q  <= '0;
      signed_q     <= 1'b0;
      weight_q     <= '0;
      done_q       <= 1'b0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      iters_q      <= iters_d;
      reads_left_q <= reads_left_d;
      reads_cfg_q  <= reads_cfg_d;
      signed_q     <= signed_d;
      weight_q     <= weight_d;
      done_q       <= done_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
    end
  end

  mul_out_fifo #(
    .Width (OutW),
    .Depth (FIFO_DEPTH)
  ) u_out_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (prod_valid_q),
    .wdata_i (prod_q),
    .pop_i   (valid_out),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: drivers queue expected product vectors, a negedge monitor
// pops and compares every output transfer.
module tb_mul_seq;

  localparam int NI = 8;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int OW = 2 * NI * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic              configure;
  logic [15:0]       num_iters;
  logic [15:0]       num_reads_per_iter;
  logic              signed_mode;
  logic [NI*DW-1:0]  act_data_in;
  logic              act_valid_in;
  logic              act_avail_out;
  logic [DW-1:0]     weight_data_in;
  logic              weight_valid_in;
  logic              weight_avail_out;
  logic [OW-1:0]     data_out;
  logic              valid_out;
  logic              avail_in;
  logic              busy_out;
  logic              done_out;

  always #5 clk = ~clk;

  mul_seq #(
    .NUM_INPUTS             (NI),
    .DATA_WIDTH             (DW),
    .LOG_MAX_ITERS          (16),
    .LOG_MAX_READS_PER_ITER (16),
    .FIFO_DEPTH             (FD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .signed_mode        (signed_mode),
    .act_data_in        (act_data_in),
    .act_valid_in       (act_valid_in),
    .act_avail_out      (act_avail_out),
    .weight_data_in     (weight_data_in),
    .weight_valid_in    (weight_valid_in),
    .weight_avail_out   (weight_avail_out),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .avail_in           (avail_in),
    .busy_out           (busy_out),
    .done_out           (done_out)
  );

  logic [OW-1:0] sb_q[$];
  int tests = 0;
  int fails = 0;
  int out_cnt, done_cnt, w_xfer;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (done_out) done_cnt++;
      if (weight_valid_in && weight_avail_out) w_xfer++;
      if (valid_out) begin
        out_cnt++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h expected none", data_out);
        end else begin
          check("output_data", data_out, sb_q.pop_front());
        end
      end
    end
  end

  function automatic logic [NI*DW-1:0] act_inc(input int base);
    logic [NI*DW-1:0] r;
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = 8'(base + i);
    return r;
  endfunction

  function automatic logic [OW-1:0] exp_vec(input logic [7:0] w, input logic [NI*DW-1:0] a,
                                            input logic sgn);
    logic [OW-1:0] r;
    int wi, ai;
    for (int i = 0; i < NI; i++) begin
      wi = sgn ? int'($signed(w)) : int'(w);
      ai = sgn ? int'($signed(a[i*DW +: DW])) : int'(a[i*DW +: DW]);
      r[i*16 +: 16] = 16'(wi * ai);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    out_cnt  = 0;
    done_cnt = 0;
    w_xfer   = 0;
  endtask

  task automatic start_job(input int iters, input int reads, input logic sgn);
    configure          = 1'b1;
    num_iters          = 16'(iters);
    num_reads_per_iter = 16'(reads);
    signed_mode        = sgn;
    tick();
    configure = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] w);
    int n = 0;
    while (!weight_avail_out && n < 200) begin tick(); n++; end
    check("weight_avail_wait", weight_avail_out, 1);
    weight_data_in  = w;
    weight_valid_in = 1'b1;
    tick();
    weight_valid_in = 1'b0;
  endtask

  task automatic send_act(input logic [NI*DW-1:0] a, input logic [OW-1:0] exp);
    int n = 0;
    while (!act_avail_out && n < 200) begin tick(); n++; end
    if (!act_avail_out) begin
      check("act_avail_wait", act_avail_out, 1);
    end else begin
      act_data_in  = a;
      act_valid_in = 1'b1;
      sb_q.push_back(exp);
      tick();
      act_valid_in = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_out && n < 300) begin tick(); n++; end
    check("done_seen", done_out, 1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_act_avail"}, act_avail_out, 0);
    check({tag, "_weight_avail"}, weight_avail_out, 0);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_done"}, done_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b0; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
    signed_mode = 1'b0; act_data_in = '0; act_valid_in = 1'b0;
    weight_data_in = '0; weight_valid_in = 1'b0; avail_in = 1'b1;
    clear_counts();
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Unsigned, two iterations of three reads
    clear_counts();
    start_job(2, 3, 1'b0);
    check("busy_after_cfg", busy_out, 1);
    send_w(8'd3);
    for (int j = 0; j < 3; j++) send_act(act_inc(1), exp_vec(8'd3, act_inc(1), 1'b0));
    send_w(8'd5);
    for (int j = 0; j < 3; j++) send_act(act_inc(1), exp_vec(8'd5, act_inc(1), 1'b0));
    wait_done();
    tick(); tick();
    check("t1_outputs", out_cnt, 6);
    check("t1_weight_xfers", w_xfer, 2);
    check("t1_done_once", done_cnt, 1);
    check("t1_busy_low", busy_out, 0);

    // Signed vs unsigned with 0xFF * 0x80
    start_job(1, 1, 1'b1);
    send_w(8'hFF);
    send_act({NI{8'h80}}, {NI{16'h0080}});
    wait_done();
    start_job(1, 1, 1'b0);
    send_w(8'hFF);
    send_act({NI{8'h80}}, {NI{16'h7F80}});
    wait_done();
    check("t2_sb_empty", OW'(sb_q.size()), 0);

    // Back-pressure: only FIFO_DEPTH vectors accepted while avail_in=0
    avail_in = 1'b0;
    clear_counts();
    start_job(1, 6, 1'b0);
    send_w(8'd7);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      act_data_in  = act_inc(16 * k);
      act_valid_in = 1'b1;
      if (act_avail_out) begin
        sb_q.push_back(exp_vec(8'd7, act_inc(16 * k), 1'b0));
        k++;
      end
      tick();
    end
    act_valid_in = 1'b0;
    check("t3_accepted", k, FD);
    check("t3_act_avail_low", act_avail_out, 0);
    check("t3_no_valid", valid_out, 0);
    avail_in = 1'b1;
    send_act(act_inc(16 * 4), exp_vec(8'd7, act_inc(16 * 4), 1'b0));
    send_act(act_inc(16 * 5), exp_vec(8'd7, act_inc(16 * 5), 1'b0));
    wait_done();
    check("t3_outputs", out_cnt, 6);
    check("t3_sb_empty", OW'(sb_q.size()), 0);

    // Zero read count: immediate done, never busy
    clear_counts();
    start_job(3, 0, 1'b0);
    check("t4_done", done_out, 1);
    check("t4_busy", busy_out, 0);
    check("t4_weight_avail", weight_avail_out, 0);
    check("t4_act_avail", act_avail_out, 0);
    tick();
    check("t4_done_pulse", done_out, 0);

    // Reconfigure attempt in RUN is ignored
    clear_counts();
    start_job(1, 2, 1'b0);
    send_w(8'd2);
    send_act(act_inc(10), exp_vec(8'd2, act_inc(10), 1'b0));
    start_job(5, 9, 1'b1);
    send_act(act_inc(20), exp_vec(8'd2, act_inc(20), 1'b0));
    wait_done();
    tick();
    check("t5_outputs", out_cnt, 2);
    check("t5_weight_xfers", w_xfer, 1);
    check("t5_idle", busy_out, 0);
    check("t5_no_restart", weight_avail_out, 0);

    // Reset mid-RUN with two entries buffered
    avail_in = 1'b0;
    clear_counts();
    start_job(1, 4, 1'b0);
    send_w(8'd9);
    send_act(act_inc(1), exp_vec(8'd9, act_inc(1), 1'b0));
    send_act(act_inc(2), exp_vec(8'd9, act_inc(2), 1'b0));
    tick(); tick();
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    sb_q.delete();
    tick();
    rst = 1'b1;
    avail_in = 1'b1;
    tick();
    clear_counts();
    start_job(1, 1, 1'b1);
    send_w(8'hFE);
    send_act({NI{8'h03}}, {NI{16'hFFFA}});
    wait_done();
    tick();
    check("t6_outputs", out_cnt, 1);
    check("t6_sb_empty", OW'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
